// File: rtl/logic_op_arbiter_if.sv
// rtl/logic_op_arbiter_if.sv - request/grant/result bundle between requesters and the arbiter
interface logic_op_arbiter_if;
  logic [3:0] req;
  logic [7:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] gnt;
  logic       y;
  logic       y_valid;
  logic       busy;

  // Requester side drives requests and operands, observes grant and result
  modport master (
    output req, op, a, b,
    input  gnt, y, y_valid, busy
  );

  // Arbiter side consumes requests and operands, produces grant and result
  modport slave (
    input  req, op, a, b,
    output gnt, y, y_valid, busy
  );
endinterface

// File: rtl/logic_op_arbiter.sv
// rtl/logic_op_arbiter.sv - 4-way round-robin arbiter executing one 1-bit logic op per grant
module logic_op_arbiter (
  input  logic               clk,
  input  logic               rst,
  logic_op_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] win_q, win_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] op_q, op_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       y_q, y_d;
  logic       y_valid_q, y_valid_d;

  logic [1:0] pick;
  logic       pick_found;
  logic       op_result;

  // Round-robin search: first asserted request at or after ptr, wrapping modulo 4
  always_comb begin
    logic [1:0] idx;
    pick       = ptr_q;
    pick_found = 1'b0;
    idx        = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + k[1:0];
      if (!pick_found && bus.req[idx]) begin
        pick       = idx;
        pick_found = 1'b1;
      end
    end
  end

  // Operation on the latched operands; inputs are never looked at after the grant
  always_comb begin
    op_result = 1'b0;
    case (op_q)
      2'b00:   op_result = a_q & b_q;
      2'b01:   op_result = a_q | b_q;
      2'b10:   op_result = a_q ^ b_q;
      default: op_result = ~a_q;
    endcase
  end

  // Next-state and registered-output logic for the IDLE -> EXEC -> DONE cycle
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    gnt_d     = gnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    y_d       = y_q;
    y_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (pick_found) begin
          win_d   = pick;
          gnt_d   = 4'b0001 << pick;
          op_d    = bus.op[{pick, 1'b0} +: 2];
          a_d     = bus.a[pick];
          b_d     = bus.b[pick];
          state_d = EXEC;
        end
      end
      EXEC: begin
        y_d       = op_result;
        y_valid_d = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        // Only the winner's own request line can release the grant
        if (!bus.req[win_q]) begin
          gnt_d   = 4'b0000;
          ptr_d   = win_q + 2'd1;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = 4'b0000;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      win_q     <= 2'd0;
      gnt_q     <= 4'b0000;
      op_q      <= 2'b00;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      y_q       <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      gnt_q     <= gnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb/tb_logic_op_arbiter.sv - randomized self-checking bench for logic_op_arbiter
module tb_logic_op_arbiter;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   m_ptr;
  int   cyc;

  logic_op_arbiter_if bus_if ();

  logic_op_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // gnt must never carry more than one bit
  always @(negedge clk) begin
    if (!rst) check("gnt_onehot0", {7'd0, $onehot0(bus_if.gnt)}, 8'd1);
  end

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic op_fn(input int code, input logic x, input logic z);
    case (code)
      0:       return x & z;
      1:       return x | z;
      2:       return x ^ z;
      default: return ~x;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble(input int w, input logic keep);
    logic [3:0] r;
    r = 4'($urandom);
    r[w] = keep;
    bus_if.req = r;
    bus_if.op  = 8'($urandom);
    bus_if.a   = 4'($urandom);
    bus_if.b   = 4'($urandom);
  endtask

  // One full transaction; hold < 0 withdraws the request during EXEC
  task automatic run_txn(input logic [3:0] r, input logic [7:0] o,
                         input logic [3:0] av, input logic [3:0] bv, input int hold);
    int   w;
    logic ey;
    bus_if.req = r;
    bus_if.op  = o;
    bus_if.a   = av;
    bus_if.b   = bv;
    w  = rr_pick(r, m_ptr);
    ey = op_fn(int'(o[2*w +: 2]), av[w], bv[w]);
    step();
    check("grant", {4'd0, bus_if.gnt}, 8'(1 << w));
    check("busy_exec", {7'd0, bus_if.busy}, 8'd1);
    check("no_yv_exec", {7'd0, bus_if.y_valid}, 8'd0);
    scramble(w, hold >= 0);
    step();
    check("y_valid", {7'd0, bus_if.y_valid}, 8'd1);
    check("y", {7'd0, bus_if.y}, {7'd0, ey});
    check("gnt_done", {4'd0, bus_if.gnt}, 8'(1 << w));
    for (int h = 0; h < hold; h++) begin
      scramble(w, 1'b1);
      step();
      check("gnt_hold", {4'd0, bus_if.gnt}, 8'(1 << w));
      check("yv_low_hold", {7'd0, bus_if.y_valid}, 8'd0);
      check("y_hold", {7'd0, bus_if.y}, {7'd0, ey});
    end
    scramble(w, 1'b0);
    step();
    check("gnt_release", {4'd0, bus_if.gnt}, 8'd0);
    check("busy_idle", {7'd0, bus_if.busy}, 8'd0);
    check("yv_low_idle", {7'd0, bus_if.y_valid}, 8'd0);
    check("y_keep", {7'd0, bus_if.y}, {7'd0, ey});
    m_ptr = (w + 1) % 4;
    bus_if.req = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    logic [7:0] o;
    logic [3:0] av;
    logic [3:0] bv;
    int         w;
    int         last_g;
    logic       ey;
    n_tests = 0;
    n_fail  = 0;
    m_ptr   = 0;
    cyc     = 0;
    rst        = 1'b1;
    bus_if.req = 4'b0000;
    bus_if.op  = 8'h00;
    bus_if.a   = 4'h0;
    bus_if.b   = 4'h0;
    #12;
    check("rst_gnt", {4'd0, bus_if.gnt}, 8'd0);
    check("rst_y", {7'd0, bus_if.y}, 8'd0);
    check("rst_yv", {7'd0, bus_if.y_valid}, 8'd0);
    check("rst_busy", {7'd0, bus_if.busy}, 8'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Idle with no requests
    step();
    check("idle_gnt", {4'd0, bus_if.gnt}, 8'd0);
    check("idle_busy", {7'd0, bus_if.busy}, 8'd0);

    // Single request: xor of 1,1 gives 0
    run_txn(4'b0001, 8'b0000_0010, 4'b0001, 4'b0001, 1);

    // Opcode sweep on requester 2 with operand flips after grant
    for (int c = 0; c < 16; c++) begin
      o = 8'($urandom);
      o[5:4] = 2'(c >> 2);
      av = 4'($urandom);
      av[2] = c[1];
      bv = 4'($urandom);
      bv[2] = c[0];
      run_txn(4'b0100, o, av, bv, int'($urandom_range(0, 3)) - 1);
    end

    // Early withdrawal on requester 1
    run_txn(4'b0010, 8'($urandom), 4'($urandom), 4'($urandom), -1);

    // Reset during EXEC aborts with no y_valid pulse
    bus_if.req = 4'b0100;
    bus_if.op  = 8'($urandom);
    bus_if.a   = 4'($urandom);
    bus_if.b   = 4'($urandom);
    step();
    check("pre_rst_gnt", {4'd0, bus_if.gnt}, 8'b0000_0100);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_gnt", {4'd0, bus_if.gnt}, 8'd0);
    check("mid_rst_yv", {7'd0, bus_if.y_valid}, 8'd0);
    check("mid_rst_busy", {7'd0, bus_if.busy}, 8'd0);
    bus_if.req = 4'b1000;
    step();
    check("rst_held_yv", {7'd0, bus_if.y_valid}, 8'd0);
    rst   = 1'b0;
    m_ptr = 0;
    run_txn(4'b1000, 8'($urandom), 4'($urandom), 4'($urandom), 0);

    // Contention: everyone requests, each drops for one cycle after its result
    bus_if.req = 4'b1111;
    bus_if.op  = 8'($urandom);
    bus_if.a   = 4'($urandom);
    bus_if.b   = 4'($urandom);
    last_g = -100;
    for (int i = 0; i < 5; i++) begin
      r  = bus_if.req;
      w  = rr_pick(r, m_ptr);
      check("cont_order", 8'(w), 8'(i % 4));
      ey = op_fn(int'(bus_if.op[2*w +: 2]), bus_if.a[w], bus_if.b[w]);
      step();
      check("cont_gnt", {4'd0, bus_if.gnt}, 8'(1 << w));
      check("cont_spacing", {7'd0, (cyc - last_g) >= 3}, 8'd1);
      last_g = cyc;
      step();
      check("cont_yv", {7'd0, bus_if.y_valid}, 8'd1);
      check("cont_y", {7'd0, bus_if.y}, {7'd0, ey});
      bus_if.req[w] = 1'b0;
      step();
      check("cont_release", {4'd0, bus_if.gnt}, 8'd0);
      bus_if.req[w] = 1'b1;
      m_ptr = (w + 1) % 4;
    end
    bus_if.req = 4'b0000;
    step();

    // Randomized transactions against the model
    for (int t = 0; t < 40; t++) begin
      r = 4'($urandom);
      if (r == 4'b0000) r = 4'b1000;
      run_txn(r, 8'($urandom), 4'($urandom), 4'($urandom),
              int'($urandom_range(0, 3)) - 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
